// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and pairs each synchronous-read imem word with its PC; one-cycle latency.
// Stall holds the presented instruction by re-reading it; a redirect overrides stall and squashes the current output.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [31:0]           if_pc,
    output logic [31:0]           if_pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] inflight_pc;
    logic        inflight_valid;
    logic [31:0] sel_pc;
    logic        advance;

    // Stalling re-selects the in-flight PC so the memory keeps returning the held word.
    always_comb begin
        sel_pc = pc_q;
        if (redirect_valid) begin
            sel_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (stall) begin
            sel_pc = inflight_pc;
        end
    end

    assign advance   = redirect_valid | ~stall;
    assign imem_addr = ADDR_WIDTH'(sel_pc[31:2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            inflight_pc    <= RESET_PC;
            inflight_valid <= 1'b0;
        end else if (advance) begin
            inflight_pc    <= sel_pc;
            inflight_valid <= 1'b1;
            pc_q           <= sel_pc + 32'd4;
        end
    end

    assign if_valid    = inflight_valid & ~redirect_valid;
    assign if_instr    = imem_rdata;
    assign if_pc       = inflight_pc;
    assign if_pc_plus4 = inflight_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory word i holds 32'h1000_0000 + i; expected PCs are queued as fetches issue.
module tb_fetch_stage;
    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc_plus4;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mpc;

    fetch_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    // Synchronous-read ROM with one-cycle latency.
    always @(posedge clk) imem_rdata <= 32'h1000_0000 + imem_addr;

    // Entered just after a rising edge; checks at the falling edge; returns just after the next rising edge.
    task automatic cyc(input logic s, input logic r, input logic [31:0] rpc,
                       input logic [AW-1:0] ea, input logic ev, input string tag);
        logic [31:0] p;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        @(negedge clk);
        checks++;
        if (imem_addr !== ea) begin
            failures++;
            $display("FAIL %s imem_addr got=%h exp=%h", tag, imem_addr, ea);
        end
        checks++;
        if (if_valid !== ev) begin
            failures++;
            $display("FAIL %s if_valid got=%b exp=%b", tag, if_valid, ev);
        end
        if (ev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s scoreboard empty while valid expected", tag);
            end else begin
                p = exp_q[0];
                checks++;
                if (if_pc !== p) begin
                    failures++;
                    $display("FAIL %s if_pc got=%h exp=%h", tag, if_pc, p);
                end
                checks++;
                if (if_instr !== 32'h1000_0000 + (p >> 2)) begin
                    failures++;
                    $display("FAIL %s if_instr got=%h exp=%h", tag, if_instr, 32'h1000_0000 + (p >> 2));
                end
                checks++;
                if (if_pc_plus4 !== p + 32'd4) begin
                    failures++;
                    $display("FAIL %s if_pc_plus4 got=%h exp=%h", tag, if_pc_plus4, p + 32'd4);
                end
            end
        end
        if (r) begin
            exp_q.delete();
            p = rpc & 32'hFFFF_FFFC;
            exp_q.push_back(p);
            mpc = p + 32'd4;
        end else if (!s) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_q.push_back(mpc);
            mpc = mpc + 32'd4;
        end
        @(posedge clk);
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    // Asserts reset between edges and checks the outputs react without a clock.
    task automatic do_reset(input string tag);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s if_valid got=%b exp=0", tag, if_valid);
        end
        checks++;
        if (imem_addr !== AW'(RPC >> 2)) begin
            failures++;
            $display("FAIL %s imem_addr got=%h exp=%h", tag, imem_addr, AW'(RPC >> 2));
        end
        exp_q.delete();
        mpc = RPC;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        do_reset("reset");
    endtask

    task automatic test_sequential();
        cyc(0, 0, 0, 32'd0, 0, "seq0");
        cyc(0, 0, 0, 32'd1, 1, "seq1");
        cyc(0, 0, 0, 32'd2, 1, "seq2");
        cyc(0, 0, 0, 32'd3, 1, "seq3");
        cyc(0, 0, 0, 32'd4, 1, "seq4");
    endtask

    task automatic test_stall();
        do_reset("stall_rst");
        cyc(0, 0, 0, 32'd0, 0, "stall_pre0");
        cyc(0, 0, 0, 32'd1, 1, "stall_pre1");
        cyc(0, 0, 0, 32'd2, 1, "stall_pre2");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'd2, 1, "stall_hold");
        cyc(0, 0, 0, 32'd3, 1, "stall_release");
        cyc(0, 0, 0, 32'd4, 1, "stall_next");
    endtask

    task automatic test_redirect();
        cyc(0, 1, 32'h40, 32'h10, 0, "redir_squash");
        cyc(0, 0, 0, 32'h11, 1, "redir_target");
        cyc(0, 0, 0, 32'h12, 1, "redir_follow");
    endtask

    task automatic test_redirect_over_stall();
        cyc(1, 1, 32'h23, 32'h08, 0, "redir_stall");
        cyc(0, 0, 0, 32'h09, 1, "redir_stall_tgt");
        cyc(0, 0, 0, 32'h0A, 1, "redir_stall_next");
    endtask

    task automatic test_back_to_back();
        cyc(0, 1, 32'h100, 32'h40, 0, "b2b_first");
        cyc(0, 1, 32'h200, 32'h80, 0, "b2b_second");
        cyc(0, 0, 0, 32'h81, 1, "b2b_target");
        cyc(0, 0, 0, 32'h82, 1, "b2b_follow");
    endtask

    task automatic test_wrap();
        cyc(0, 1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 0, "wrap_redir");
        cyc(0, 0, 0, 32'h0, 1, "wrap_top");
        cyc(0, 0, 0, 32'h1, 1, "wrap_zero");
    endtask

    task automatic test_stall_idle();
        do_reset("idle_rst");
        cyc(1, 0, 0, 32'd0, 0, "idle_stall0");
        cyc(1, 0, 0, 32'd0, 0, "idle_stall1");
        cyc(0, 0, 0, 32'd0, 0, "idle_go");
        cyc(0, 0, 0, 32'd1, 1, "idle_first");
    endtask

    task automatic test_mid_reset();
        cyc(0, 1, 32'h80, 32'h20, 0, "mid_redir");
        cyc(0, 0, 0, 32'h21, 1, "mid_run");
        do_reset("mid_reset");
        cyc(0, 0, 0, 32'd0, 0, "mid_restart0");
        cyc(0, 0, 0, 32'd1, 1, "mid_restart1");
        cyc(0, 0, 0, 32'd2, 1, "mid_restart2");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_back_to_back();
        test_wrap();
        test_stall_idle();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage driving the word-addressed, synchronous-read instruction memory (one-cycle read latency).
- Owns the PC, issues one read address per cycle, and pairs each returned instruction with its PC.
- Presents the fetched instruction to decode with a valid flag.
- Supports stall from the hazard unit and PC redirect (branch/jump) from later stages, squashing the wrong-path fetch.

Parameters:
- ADDR_WIDTH, 32, width of the instruction-memory word address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept this cycle; hold the current instruction.
- redirect_valid  in  1  replace the fetch stream with redirect_pc.
- redirect_pc  in  32  byte target address; bits [1:0] are ignored (treated as 0).
- imem_addr  out  ADDR_WIDTH  word address sampled by the memory at the next rising edge; equals the selected byte PC >> 2, zero-extended or truncated to ADDR_WIDTH.
- imem_rdata  in  DATA_WIDTH  memory data; corresponds to the address sampled at the previous edge.
- if_valid  out  1  if_instr/if_pc are a real instruction.
- if_instr  out  DATA_WIDTH  instruction, equal to imem_rdata.
- if_pc  out  32  byte PC of if_instr.
- if_pc_plus4  out  32  if_pc + 4, modulo 2^32.

Behaviour:
- State:
  - pc_q (32): next byte PC to request.
  - inflight_pc (32): PC of the read whose data is now on imem_rdata.
  - inflight_valid (1).
- Reset (asserted asynchronously, effective immediately, including mid-operation):
  - pc_q = RESET_PC; inflight_pc = RESET_PC; inflight_valid = 0.
  - if_valid = 0; imem_addr = RESET_PC >> 2.
- Per-cycle selection (combinational, priority order):
  1. redirect_valid = 1: imem_addr = redirect_pc >> 2. At the edge, inflight_pc <= {redirect_pc[31:2], 2'b00}, inflight_valid <= 1, pc_q <= that value + 4. Overrides stall.
  2. stall = 1, no redirect: imem_addr = inflight_pc >> 2, so the memory re-reads the held instruction. All registers hold.
  3. Otherwise: imem_addr = pc_q >> 2. At the edge, inflight_pc <= pc_q, inflight_valid <= 1, pc_q <= pc_q + 4.
- Outputs:
  - if_valid = inflight_valid & ~redirect_valid. The wrong-path instruction is squashed in the same cycle as the redirect.
  - if_pc = inflight_pc; if_pc_plus4 = inflight_pc + 4; if_instr = imem_rdata.
- Latency: an address selected in cycle n appears as an if_* instruction in cycle n+1. Steady state delivers one instruction per cycle.
- After reset release: cycle 0 has if_valid = 0 and requests RESET_PC; cycle 1 has if_valid = 1 and if_pc = RESET_PC.
- Stall with inflight_valid = 0: holds, if_valid stays 0, re-reads inflight_pc. This is harmless because the memory is read-only.
- Back-to-back redirects: each redirect squashes the current output. The last target is the one fetched.
- PC arithmetic wraps modulo 2^32: pc_q = 32'hFFFF_FFFC advances to 0.
- imem_addr, if_valid and if_instr have combinational paths from redirect_valid, redirect_pc, stall and imem_rdata. No other combinational input-to-output paths exist.
- if_instr is undefined while if_valid = 0. Downstream must qualify it with if_valid.

Test Plan:
- Reset release, RESET_PC = 0, memory holding word i = 32'h1000_0000 + i, no stall/redirect for 5 cycles -> imem_addr 0,1,2,3,4; if_valid 0,1,1,1,1; if_pc 0,4,8,12; if_instr 32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003; if_pc_plus4 = if_pc + 4.
- Stall for 3 cycles while if_pc = 8 -> if_valid = 1, if_pc = 8, if_instr = 32'h1000_0002 held all 3 cycles with imem_addr = 2; after release the next if_pc = 12, with no skip or duplicate.
- redirect_valid with redirect_pc = 32'h40 while if_pc = 12 -> if_valid = 0 that cycle; next cycle if_pc = 32'h40 with if_instr = word 16; then 32'h44.
- redirect and stall asserted together, redirect_pc = 32'h23 -> redirect wins, bits [1:0] are dropped, next if_pc = 32'h20.
- rst_n asserted mid-stream without a clock edge -> if_valid drops to 0 immediately; after release the fetch restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC -> if_pc = 32'hFFFF_FFFC and if_pc_plus4 = 0; the following if_pc = 0.
